db_hash_table: RTL

// - Parametrised key/value store for the filtering path: hashes a KEY_SIZE key, indexes an on-chip WAYS-way set-associative table.
// - Executes LOOKUP / INSERT / DELETE per request; returns a result code plus the stored value.
// - Sits between the packet parser (request side) and the filter/action logic (response side).
// - Adds valid/ready backpressure on both sides, multi-way buckets with replacement, and a post-reset table clear.

---
 rtl/db_hash_table_pkg.sv | 42 ++++
 rtl/db_hash_crc32.sv | 38 +++
 rtl/db_hash_table.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/db_hash_table_pkg.sv
// Shared definitions for the db_hash_table key/value store:
// opcodes, result codes, value status codes and FSM encoding.
package db_hash_table_pkg;

    localparam logic [3:0] OP_NOP    = 4'd0;
    localparam logic [3:0] OP_LOOKUP = 4'd1;
    localparam logic [3:0] OP_INSERT = 4'd2;
    localparam logic [3:0] OP_DELETE = 4'd3;

    localparam logic [3:0] RES_MISS     = 4'd0;
    localparam logic [3:0] RES_HIT      = 4'd1;
    localparam logic [3:0] RES_INSERTED = 4'd2;
    localparam logic [3:0] RES_UPDATED  = 4'd3;
    localparam logic [3:0] RES_EVICTED  = 4'd4;
    localparam logic [3:0] RES_DELETED  = 4'd5;
    localparam logic [3:0] RES_DEL_MISS = 4'd6;
    localparam logic [3:0] RES_BAD_OP   = 4'd7;
    localparam logic [3:0] RES_NOP_ACK  = 4'd8;

    // Status codes carried in value[3:0] by the filter/action logic
    localparam logic [3:0] STAT_SUSPECTION = 4'd1;
    localparam logic [3:0] STAT_ARREST     = 4'd2;
    localparam logic [3:0] STAT_FILTERED   = 4'd3;
    localparam logic [3:0] STAT_EXPIRED    = 4'd4;

    localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_HASH,
        ST_READ,
        ST_CMP,
        ST_RESP
    } state_t;

    function automatic bit is_table_op(input logic [3:0] op);
        return (op == OP_LOOKUP) || (op == OP_INSERT) || (op == OP_DELETE);
    endfunction

endpackage

// File: rtl/db_hash_crc32.sv
// Registered CRC32 of a KEY_SIZE-bit key, MSB first,
// non-reflected, init all-ones, no final xor.
module db_hash_crc32
    import db_hash_table_pkg::*;
#(
    parameter int KEY_SIZE = 96
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [KEY_SIZE-1:0] data,
    output logic [31:0]         crc
);

    function automatic logic [31:0] crc_calc(input logic [KEY_SIZE-1:0] d);
        logic [31:0] c;
        logic        fb;
        c = CRC_INIT;
        for (int i = KEY_SIZE - 1; i >= 0; i--) begin
            fb = c[31] ^ d[i];
            c  = {c[30:0], 1'b0};
            if (fb) begin
                c = c ^ CRC_POLY;
            end
        end
        return c;
    endfunction

    // Capture the hash only when the FSM asks for it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= '0;
        end else if (en) begin
            crc <= crc_calc(data);
        end
    end

endmodule

// File: rtl/db_hash_table.sv
// Set-associative key/value store: hash, read set, compare,
// update and respond, one request in flight at a time.
module db_hash_table
    import db_hash_table_pkg::*;
#(
    parameter int KEY_SIZE = 96,
    parameter int VAL_SIZE = 32,
    parameter int IDX_BITS = 10,
    parameter int WAYS     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3:0]          in_flag,
    input  logic [KEY_SIZE-1:0] in_key,
    input  logic [VAL_SIZE-1:0] in_value,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [3:0]          out_flag,
    output logic [VAL_SIZE-1:0] out_value,
    output logic                init_done
);

    localparam int ENT_W = 1 + KEY_SIZE + VAL_SIZE;
    localparam int SET_W = WAYS * ENT_W;
    localparam int DEPTH = 1 << IDX_BITS;
    localparam int WIDX  = (WAYS > 1) ? $clog2(WAYS) : 1;

    state_t              state;
    logic [IDX_BITS-1:0] clr_ptr;
    logic [3:0]          op_q;
    logic [KEY_SIZE-1:0] key_q;
    logic [VAL_SIZE-1:0] val_q;

    logic [31:0]         crc;
    logic                crc_unused;
    logic [IDX_BITS-1:0] set_idx;

    logic [SET_W-1:0]    mem [DEPTH];
    logic [SET_W-1:0]    rdata;
    logic                we;
    logic [IDX_BITS-1:0] waddr;
    logic [SET_W-1:0]    wdata;
    logic [SET_W-1:0]    set_wr;

    logic [DEPTH*WIDX-1:0] victim;
    logic [WIDX-1:0]       vic_way;
    logic [WIDX-1:0]       vic_next;

    logic [WAYS-1:0]     w_valid;
    logic [KEY_SIZE-1:0] w_key [WAYS];
    logic [VAL_SIZE-1:0] w_val [WAYS];

    logic                hit;
    logic [WIDX-1:0]     hit_way;
    logic                free;
    logic [WIDX-1:0]     free_way;

    logic [3:0]          resp_flag;
    logic [VAL_SIZE-1:0] resp_val;
    logic                cmp_we;
    logic                vp_bump;
    logic [WIDX-1:0]     tgt_way;
    logic                new_valid;
    logic [VAL_SIZE-1:0] new_val;

    assign set_idx    = crc[IDX_BITS-1:0];
    assign crc_unused = ^crc[31:IDX_BITS];

    db_hash_crc32 #(
        .KEY_SIZE(KEY_SIZE)
    ) u_crc (
        .clk (clk),
        .rst (rst),
        .en  (state == ST_HASH),
        .data(key_q),
        .crc (crc)
    );

    // Split the registered set into per-way fields
    always_comb begin
        w_valid = '0;
        for (int w = 0; w < WAYS; w++) begin
            w_valid[w] = rdata[w*ENT_W + ENT_W - 1];
            w_key[w]   = rdata[w*ENT_W + VAL_SIZE +: KEY_SIZE];
            w_val[w]   = rdata[w*ENT_W +: VAL_SIZE];
        end
    end

    // Lowest valid matching way and lowest free way
    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        free     = 1'b0;
        free_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (w_valid[w] && (w_key[w] == key_q)) begin
                hit     = 1'b1;
                hit_way = WIDX'(w);
            end
            if (!w_valid[w]) begin
                free     = 1'b1;
                free_way = WIDX'(w);
            end
        end
    end

    // Round-robin replacement pointer of the current set
    always_comb begin
        vic_way  = victim[int'(set_idx)*WIDX +: WIDX];
        vic_next = (int'(vic_way) >= WAYS - 1) ? '0 : vic_way + 1'b1;
    end

    // Decide the response and the way update for this request
    always_comb begin
        resp_flag = RES_BAD_OP;
        resp_val  = '0;
        cmp_we    = 1'b0;
        vp_bump   = 1'b0;
        tgt_way   = hit_way;
        new_valid = 1'b1;
        new_val   = val_q;
        unique case (op_q)
            OP_NOP: begin
                resp_flag = RES_NOP_ACK;
            end
            OP_LOOKUP: begin
                if (hit) begin
                    resp_flag = RES_HIT;
                    resp_val  = w_val[hit_way];
                end else begin
                    resp_flag = RES_MISS;
                end
            end
            OP_INSERT: begin
                cmp_we = 1'b1;
                if (hit) begin
                    resp_flag = RES_UPDATED;
                    resp_val  = w_val[hit_way];
                end else if (free) begin
                    tgt_way   = free_way;
                    resp_flag = RES_INSERTED;
                end else begin
                    tgt_way   = vic_way;
                    resp_flag = RES_EVICTED;
                    resp_val  = w_val[vic_way];
                    vp_bump   = 1'b1;
                end
            end
            OP_DELETE: begin
                if (hit) begin
                    cmp_we    = 1'b1;
                    new_valid = 1'b0;
                    new_val   = w_val[hit_way];
                    resp_flag = RES_DELETED;
                    resp_val  = w_val[hit_way];
                end else begin
                    resp_flag = RES_DEL_MISS;
                end
            end
            default: begin
                resp_flag = RES_BAD_OP;
            end
        endcase
    end

    // Write port: clear sweep during INIT, way update in CMP
    always_comb begin
        set_wr = rdata;
        set_wr[int'(tgt_way)*ENT_W +: ENT_W] = {new_valid, key_q, new_val};
        we     = (state == ST_INIT) || ((state == ST_CMP) && cmp_we);
        waddr  = (state == ST_INIT) ? clr_ptr : set_idx;
        wdata  = (state == ST_INIT) ? '0 : set_wr;
    end

    // Table RAM: one write port, registered read of a full set
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (state == ST_READ) begin
            rdata <= mem[set_idx];
        end
    end

    // Advance the replacement pointer after an eviction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            victim <= '0;
        end else if ((state == ST_CMP) && vp_bump) begin
            victim[int'(set_idx)*WIDX +: WIDX] <= vic_next;
        end
    end

    // Request sequencer with registered handshake and response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_INIT;
            clr_ptr   <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_flag  <= '0;
            out_value <= '0;
            init_done <= 1'b0;
            op_q      <= '0;
            key_q     <= '0;
            val_q     <= '0;
        end else begin
            unique case (state)
                ST_INIT: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == '1) begin
                        init_done <= 1'b1;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        op_q     <= in_flag;
                        key_q    <= in_key;
                        val_q    <= in_value;
                        in_ready <= 1'b0;
                        state    <= is_table_op(in_flag) ? ST_HASH : ST_CMP;
                    end
                end
                ST_HASH: begin
                    state <= ST_READ;
                end
                ST_READ: begin
                    state <= ST_CMP;
                end
                ST_CMP: begin
                    out_valid <= 1'b1;
                    out_flag  <= resp_flag;
                    out_value <= resp_val;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_flag  <= '0;
                        out_value <= '0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

endmodule
